lsm_continuation_eval: RTL and testbench
========================================

# lsm_continuation_eval

Downstream consumer of the regression stage in the Longstaff-Schwartz option pricer. The block loads one set of quadratic regression coefficients (b0, b1, b2) per exercise date. It then streams N path samples and evaluates the continuation value cont = b0 + b1·x + b2·x² for each path. It compares cont against the immediate exercise value and emits the per-path exercise decision and updated cashflow. That cashflow becomes yi for the next backward time step.

## Interface
- N, 256: number of path samples per exercise date.
- XW, 12: width of price, exercise and cashflow words (unsigned Q8.4).
- CW, 16: width of each coefficient (signed Q8.8).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- coef_valid  in  1  single-cycle pulse; loads b0/b1/b2.
- b0, b1, b2  in  CW each  regression coefficients, signed Q8.8.
- in_valid  in  1  sample present on xi/ex/yi.
- in_ready  out  1  high while samples are being accepted.
- xi  in  XW  underlying price of the path, Q8.4.
- ex  in  XW  immediate exercise value, Q8.4; 0 means out of the money.
- yi  in  XW  currently held discounted cashflow, Q8.4.
- out_valid  out  1  result valid, one cycle per accepted sample.
- exercise  out  1  1 means exercise now.
- cashflow  out  XW  ex if exercise, else yi.
- done  out  1  pulse coincident with the N-th out_valid.

## Operation
- States: IDLE, EVAL, DRAIN.
  - IDLE: coef_valid latches the coefficients and moves the block to EVAL.
  - EVAL: in_ready=1. Each in_valid&&in_ready increments the sample count (0..N-1). On the N-th accept the block moves to DRAIN.
  - DRAIN: in_ready=0. When the last result issues, done pulses and the block returns to IDLE.
- coef_valid outside IDLE is ignored; coefficients cannot change mid-batch.
- in_valid while in_ready=0 is ignored: not counted, no output.
- Arithmetic is exact, with no intermediate truncation:
  - x² is 24-bit unsigned, Q16.8.
  - b1·x is aligned to Q.16 by <<4.
  - b0 is aligned by <<8.
  - b2·x² is natively Q.16.
  - Terms are summed in a 42-bit signed accumulator.
- Continuation result: arithmetic shift right by 12 (floor) to Q8.4. Saturate below 0 to 0 and above 4095 to 4095; the result is cont_sat.
- Decision: exercise = (ex > cont_sat). A tie means no exercise. cashflow = exercise ? ex : yi.
- Out-of-the-money (ex==0) with the feature compiled in is described under Configuration.

## Timing
- Fixed latency of 3 cycles from accept edge to out_valid.
- Full throughput: one sample per cycle, with no bubbles required.
- There is no output backpressure; the consumer must always accept.
- in_ready goes low in the cycle after the N-th accept. It never drops early.
- done asserts in the same cycle as the final out_valid, exactly once per batch.
- A coef_valid in the same cycle done pulses is ignored (state is DRAIN). The next batch needs a coef_valid in IDLE, at least 1 cycle after done.
- Reset values:
  - state=IDLE, count=0, coefficients=0.
  - The valid bits of all pipeline stages are cleared.
  - Outputs: in_ready=0, out_valid=0, exercise=0, cashflow=0, done=0.
- Reset mid-batch discards all in-flight samples; nothing is emitted after reset release until a new coef_valid arrives.

## Configuration
- ITM_FILTER_EN defined: a sample with ex==0 forces exercise=0 and cashflow=yi regardless of cont_sat. The latency and count are unchanged.
- ITM_FILTER_EN undefined: the normal comparison applies to every sample. Because cont_sat≥0, ex==0 never exercises, so the filter is functionally redundant. Without the filter, the comparator path is exercised on all samples for power/debug comparison.

## Structure
- Package lsm_pkg holds:
  - XW, CW, the fraction constants (X_FRAC=4, C_FRAC=8) and the accumulator width (42).
  - A typedef for the unsigned Q8.4 word and one for the signed Q8.8 coefficient.
- Sub-module poly_eval implements the 3-stage pipelined quadratic with saturation. It is a valid-in/valid-out datapath with no control.
- The top level owns the FSM, the sample counter, the coefficient registers, and the ex/yi delay lines matched to the poly_eval latency.

## Test plan
- b0=256 (1.0), b1=b2=0; xi=160, ex=32, yi=48 -> after 3 cycles exercise=1, cashflow=32.
- b0=1280 (5.0), b1=b2=0; ex=32, yi=48 -> exercise=0, cashflow=48.
- b0=b1=0, b2=64 (0.25); xi=64 (4.0), ex=64, yi=10 -> cont_sat=64, tie, exercise=0, cashflow=10.
- Saturation, both ends:
  - b0=-2560; ex=1 -> cont_sat=0, exercise=1, cashflow=1.
  - b0=32512, b2=256; xi=4095, ex=4095 -> cont_sat=4095, exercise=0.
- Batch control with N=4 and 5 back-to-back in_valid:
  - Exactly 4 outputs are produced; in_ready falls after the 4th accept.
  - done coincides with the 4th out_valid.
  - The 5th sample is ignored.
  - A coef_valid issued during DRAIN is ignored.
- Mid-batch reset after 2 accepts:
  - rst_n low -> all outputs 0.
  - After release with no coef_valid, in_valid produces no out_valid.
  - A new coef_valid starts a fresh count of N.

Source files
------------

// File: rtl/lsm_pkg.sv
// Shared widths, fixed-point formats and saturation helper for the LSM
// continuation-value evaluator.
package lsm_pkg;

  localparam int XW        = 12;
  localparam int CW        = 16;
  localparam int X_FRAC    = 4;
  localparam int C_FRAC    = 8;
  localparam int ACC_W     = 42;

  // Every polynomial term is aligned to this fraction before summing.
  localparam int Q_FRAC    = C_FRAC + 2 * X_FRAC;
  localparam int OUT_SHIFT = Q_FRAC - X_FRAC;

  localparam int XSQ_W     = 2 * XW;
  localparam int B1X_W     = CW + XW + 1;
  localparam int B2X_W     = CW + XSQ_W + 1;

  typedef logic [XW-1:0]           q84_t;
  typedef logic signed [CW-1:0]    q88_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Floor to Q8.4 and clamp into the unsigned 12-bit range.
  function automatic q84_t sat_q84(input acc_t acc);
    acc_t q;
    q = acc >>> OUT_SHIFT;
    if (acc[ACC_W-1])
      return '0;
    else if (q > acc_t'(2**XW - 1))
      return '1;
    else
      return q[XW-1:0];
  endfunction

endpackage

// File: rtl/lsm_continuation_eval_poly_eval.sv
// Three-stage pipelined evaluation of b0 + b1*x + b2*x^2 with exact
// arithmetic and Q8.4 saturation; pure valid-in/valid-out datapath.
module poly_eval
  import lsm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] b0,
  input  logic [CW-1:0] b1,
  input  logic [CW-1:0] b2,
  input  logic [XW-1:0] x,
  output logic          out_valid,
  output logic [XW-1:0] cont_sat
);

  logic                    v1, v2, v3;
  logic [XSQ_W-1:0]        xsq1;
  logic signed [B1X_W-1:0] b1x1;
  acc_t                    t2, p2;
  q84_t                    cont3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      xsq1 <= '0;
      b1x1 <= '0;
    end else begin
      v1   <= in_valid;
      xsq1 <= XSQ_W'(x) * XSQ_W'(x);
      b1x1 <= B1X_W'($signed(b1)) * B1X_W'($signed({1'b0, x}));
    end
  end

  // b1*x and b0 are shifted up to the Q.16 grid shared with b2*x^2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      t2 <= '0;
      p2 <= '0;
    end else begin
      v2 <= v1;
      t2 <= ACC_W'(B2X_W'($signed(b2)) * B2X_W'($signed({1'b0, xsq1})));
      p2 <= (ACC_W'(b1x1) <<< X_FRAC) + (ACC_W'($signed(b0)) <<< (2 * X_FRAC));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      cont3 <= '0;
    end else begin
      v3    <= v2;
      cont3 <= sat_q84(t2 + p2);
    end
  end

  assign out_valid = v3;
  assign cont_sat  = cont3;

endmodule

// File: rtl/lsm_continuation_eval.sv
// Per-path exercise decision for one exercise date: batch FSM, coefficient
// registers and delay lines around poly_eval. Optional macro: ITM_FILTER_EN.
//
// state   | meaning
// IDLE    | waiting for coef_valid to latch b0/b1/b2
// EVAL    | accepting N samples (in_ready=1)
// DRAIN   | flushing the pipeline; leaves after done
module lsm_continuation_eval
  import lsm_pkg::*;
#(
  parameter int N = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_valid,
  input  logic [CW-1:0] b0,
  input  logic [CW-1:0] b1,
  input  logic [CW-1:0] b2,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] xi,
  input  logic [XW-1:0] ex,
  input  logic [XW-1:0] yi,
  output logic          out_valid,
  output logic          exercise,
  output logic [XW-1:0] cashflow,
  output logic          done
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  q88_t             b0_q, b1_q, b2_q;
  logic             accept, last_accept;

  logic             cont_valid;
  q84_t             cont_sat;
  q84_t             ex_d [3];
  q84_t             yi_d [3];
  logic [2:0]       last_d;
  logic             exercise_nxt;

  assign in_ready    = (state == S_EVAL);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (count == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
      b2_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (coef_valid) begin
            b0_q  <= b0;
            b1_q  <= b1;
            b2_q  <= b2;
            count <= '0;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (last_accept) begin
            count <= '0;
            state <= S_DRAIN;
          end else if (accept) begin
            count <= count + 1'b1;
          end
        end
        // Stay here through the done cycle so a coincident coef_valid is dropped.
        S_DRAIN: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  poly_eval u_poly_eval (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .b0        (b0_q),
    .b1        (b1_q),
    .b2        (b2_q),
    .x         (xi),
    .out_valid (cont_valid),
    .cont_sat  (cont_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        ex_d[i] <= '0;
        yi_d[i] <= '0;
      end
      last_d <= '0;
    end else begin
      ex_d[0] <= ex;
      yi_d[0] <= yi;
      for (int i = 1; i < 3; i++) begin
        ex_d[i] <= ex_d[i-1];
        yi_d[i] <= yi_d[i-1];
      end
      last_d <= {last_d[1:0], last_accept};
    end
  end

  always_comb begin
    exercise_nxt = (ex_d[2] > cont_sat);
`ifdef ITM_FILTER_EN
    if (ex_d[2] == '0) exercise_nxt = 1'b0;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      exercise  <= 1'b0;
      cashflow  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= cont_valid;
      exercise  <= cont_valid && exercise_nxt;
      cashflow  <= cont_valid ? (exercise_nxt ? ex_d[2] : yi_d[2]) : '0;
      done      <= cont_valid && last_d[2];
    end
  end

endmodule

// File: tb/tb_lsm_continuation_eval.sv
// Directed self-checking bench for lsm_continuation_eval with N=4.
module tb_lsm_continuation_eval;

  logic        clk, rst_n;
  logic        coef_valid;
  logic [15:0] b0, b1, b2;
  logic        in_valid, in_ready;
  logic [11:0] xi, ex, yi;
  logic        out_valid, exercise, done;
  logic [11:0] cashflow;

  int tests_run = 0;
  int fails     = 0;

  // {done, exercise, cashflow} of every result seen
  logic [13:0] outq[$];

  lsm_continuation_eval #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_valid (coef_valid),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .xi         (xi),
    .ex         (ex),
    .yi         (yi),
    .out_valid  (out_valid),
    .exercise   (exercise),
    .cashflow   (cashflow),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) outq.push_back({done, exercise, cashflow});

  task automatic load_coef(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    coef_valid = 1'b1; b0 = c0; b1 = c1; b2 = c2;
    @(posedge clk); #1;
    coef_valid = 1'b0;
  endtask

  task automatic run_batch(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                           input logic [11:0] xv [4], input logic [11:0] ev [4], input logic [11:0] yv [4]);
    outq.delete();
    load_coef(c0, c1, c2);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; xi = xv[i]; ex = ev[i]; yi = yv[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({in_ready, out_valid, exercise, cashflow, done} !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got ir=%b ov=%b ex=%b cf=%0d dn=%b, want all 0",
               in_ready, out_valid, exercise, cashflow, done);
    end
  endtask

  task automatic test_exercise_basic();
    logic [11:0] xv [4] = '{12'd160, 12'd0, 12'd4095, 12'd100};
    logic [11:0] ev [4] = '{12'd32, 12'd16, 12'd0, 12'd17};
    logic [11:0] yv [4] = '{12'd48, 12'd5, 12'd7, 12'd9};
    logic [13:0] want [4] = '{{2'b01, 12'd32}, {2'b00, 12'd5}, {2'b00, 12'd7}, {2'b11, 12'd17}};
    logic [13:0] got;
    run_batch(16'd256, 16'd0, 16'd0, xv, ev, yv);
    tests_run++;
    if (outq.size() !== 4) begin fails++; $display("FAIL basic_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < outq.size()) ? outq[i] : 14'bx;
      tests_run++;
      if (got !== want[i]) begin
        fails++;
        $display("FAIL basic[%0d]: got dn/ex/cf=%b/%b/%0d want %b/%b/%0d", i,
                 got[13], got[12], got[11:0], want[i][13], want[i][12], want[i][11:0]);
      end
    end
  endtask

  task automatic test_hold();
    logic [11:0] xv [4] = '{12'd0, 12'd50, 12'd50, 12'd4095};
    logic [11:0] ev [4] = '{12'd32, 12'd81, 12'd80, 12'd4095};
    logic [11:0] yv [4] = '{12'd48, 12'd3, 12'd3, 12'd1};
    logic [13:0] want [4] = '{{2'b00, 12'd48}, {2'b01, 12'd81}, {2'b00, 12'd3}, {2'b11, 12'd4095}};
    logic [13:0] got;
    run_batch(16'd1280, 16'd0, 16'd0, xv, ev, yv);
    tests_run++;
    if (outq.size() !== 4) begin fails++; $display("FAIL hold_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < outq.size()) ? outq[i] : 14'bx;
      tests_run++;
      if (got !== want[i]) begin
        fails++;
        $display("FAIL hold[%0d]: got dn/ex/cf=%b/%b/%0d want %b/%b/%0d", i,
                 got[13], got[12], got[11:0], want[i][13], want[i][12], want[i][11:0]);
      end
    end
  endtask

  task automatic test_quadratic_tie();
    logic [11:0] xv [4] = '{12'd64, 12'd128, 12'd32, 12'd0};
    logic [11:0] ev [4] = '{12'd64, 12'd257, 12'd15, 12'd1};
    logic [11:0] yv [4] = '{12'd10, 12'd2, 12'd4, 12'd6};
    logic [13:0] want [4] = '{{2'b00, 12'd10}, {2'b01, 12'd257}, {2'b00, 12'd4}, {2'b11, 12'd1}};
    logic [13:0] got;
    run_batch(16'd0, 16'd0, 16'd64, xv, ev, yv);
    tests_run++;
    if (outq.size() !== 4) begin fails++; $display("FAIL quad_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < outq.size()) ? outq[i] : 14'bx;
      tests_run++;
      if (got !== want[i]) begin
        fails++;
        $display("FAIL quad[%0d]: got dn/ex/cf=%b/%b/%0d want %b/%b/%0d", i,
                 got[13], got[12], got[11:0], want[i][13], want[i][12], want[i][11:0]);
      end
    end
  endtask

  // cont = 10.0 - x with a negative linear coefficient
  task automatic test_linear();
    logic [11:0] xv [4] = '{12'd64, 12'd64, 12'd320, 12'd0};
    logic [11:0] ev [4] = '{12'd97, 12'd96, 12'd0, 12'd160};
    logic [11:0] yv [4] = '{12'd1, 12'd2, 12'd3, 12'd4};
    logic [13:0] want [4] = '{{2'b01, 12'd97}, {2'b00, 12'd2}, {2'b00, 12'd3}, {2'b10, 12'd4}};
    logic [13:0] got;
    run_batch(16'd2560, 16'hFF00, 16'd0, xv, ev, yv);
    tests_run++;
    if (outq.size() !== 4) begin fails++; $display("FAIL linear_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < outq.size()) ? outq[i] : 14'bx;
      tests_run++;
      if (got !== want[i]) begin
        fails++;
        $display("FAIL linear[%0d]: got dn/ex/cf=%b/%b/%0d want %b/%b/%0d", i,
                 got[13], got[12], got[11:0], want[i][13], want[i][12], want[i][11:0]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [11:0] xl [4] = '{12'd100, 12'd0, 12'd4095, 12'd5};
    logic [11:0] el [4] = '{12'd1, 12'd0, 12'd2, 12'd0};
    logic [11:0] yl [4] = '{12'd9, 12'd9, 12'd3, 12'd0};
    logic [13:0] wl [4] = '{{2'b01, 12'd1}, {2'b00, 12'd9}, {2'b01, 12'd2}, {2'b10, 12'd0}};
    logic [11:0] xh [4] = '{12'd4095, 12'd0, 12'd0, 12'd16};
    logic [11:0] eh [4] = '{12'd4095, 12'd2033, 12'd2032, 12'd4095};
    logic [11:0] yh [4] = '{12'd11, 12'd1, 12'd2, 12'd3};
    logic [13:0] wh [4] = '{{2'b00, 12'd11}, {2'b01, 12'd2033}, {2'b00, 12'd2}, {2'b11, 12'd4095}};
    logic [13:0] got;
    run_batch(16'hF600, 16'd0, 16'd0, xl, el, yl);
    tests_run++;
    if (outq.size() !== 4) begin fails++; $display("FAIL satlo_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < outq.size()) ? outq[i] : 14'bx;
      tests_run++;
      if (got !== wl[i]) begin
        fails++;
        $display("FAIL satlo[%0d]: got dn/ex/cf=%b/%b/%0d want %b/%b/%0d", i,
                 got[13], got[12], got[11:0], wl[i][13], wl[i][12], wl[i][11:0]);
      end
    end
    run_batch(16'h7F00, 16'd0, 16'd256, xh, eh, yh);
    tests_run++;
    if (outq.size() !== 4) begin fails++; $display("FAIL sathi_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < outq.size()) ? outq[i] : 14'bx;
      tests_run++;
      if (got !== wh[i]) begin
        fails++;
        $display("FAIL sathi[%0d]: got dn/ex/cf=%b/%b/%0d want %b/%b/%0d", i,
                 got[13], got[12], got[11:0], wh[i][13], wh[i][12], wh[i][11:0]);
      end
    end
  endtask

  // Five back-to-back samples; coef_valid pulsed in DRAIN and in the done cycle.
  task automatic test_back_to_back();
    logic        ov_w, ir_w, dn_w;
    logic [11:0] cf_w;
    load_coef(16'd256, 16'd0, 16'd0);
    for (int k = 0; k < 10; k++) begin
      in_valid   = (k < 5);
      xi         = 12'd0;
      ex         = 12'(32 + k);
      yi         = 12'd48;
      coef_valid = (k == 4 || k == 7);
      b0         = 16'h7F00;
      @(posedge clk); #1;
      ov_w = (k >= 3 && k <= 6);
      ir_w = (k <= 2);
      dn_w = (k == 6);
      cf_w = ov_w ? 12'(32 + k - 3) : 12'd0;
      tests_run++;
      if ({out_valid, in_ready, done, exercise, cashflow} !== {ov_w, ir_w, dn_w, ov_w, cf_w}) begin
        fails++;
        $display("FAIL b2b[%0d]: got ov/ir/dn/ex/cf=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                 out_valid, in_ready, done, exercise, cashflow, ov_w, ir_w, dn_w, ov_w, cf_w);
      end
    end
    in_valid = 1'b0; coef_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: got in_ready=%b want 0", in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] xv [4] = '{12'd0, 12'd0, 12'd0, 12'd0};
    logic [11:0] ev [4] = '{12'd32, 12'd81, 12'd80, 12'd100};
    logic [11:0] yv [4] = '{12'd48, 12'd1, 12'd2, 12'd3};
    logic [13:0] want [4] = '{{2'b00, 12'd48}, {2'b01, 12'd81}, {2'b00, 12'd2}, {2'b11, 12'd100}};
    logic [13:0] got;
    load_coef(16'd256, 16'd0, 16'd0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; xi = 12'd0; ex = 12'd32; yi = 12'd48;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    tests_run++;
    if ({out_valid, exercise, cashflow} !== {2'b11, 12'd32}) begin
      fails++;
      $display("FAIL pre_reset_out: got ov/ex/cf=%b/%b/%0d want 1/1/32", out_valid, exercise, cashflow);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, out_valid, exercise, cashflow, done} !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got ir=%b ov=%b ex=%b cf=%0d dn=%b, want all 0",
               in_ready, out_valid, exercise, cashflow, done);
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    outq.delete();
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 6); xi = 12'd0; ex = 12'd32; yi = 12'd48;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests_run++;
    if (outq.size() !== 0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_quiet: got outputs=%0d in_ready=%b want 0/0", outq.size(), in_ready);
    end
    run_batch(16'd1280, 16'd0, 16'd0, xv, ev, yv);
    tests_run++;
    if (outq.size() !== 4) begin fails++; $display("FAIL fresh_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < outq.size()) ? outq[i] : 14'bx;
      tests_run++;
      if (got !== want[i]) begin
        fails++;
        $display("FAIL fresh[%0d]: got dn/ex/cf=%b/%b/%0d want %b/%b/%0d", i,
                 got[13], got[12], got[11:0], want[i][13], want[i][12], want[i][11:0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; coef_valid = 1'b0; in_valid = 1'b0;
    b0 = '0; b1 = '0; b2 = '0; xi = '0; ex = '0; yi = '0;
    repeat (3) @(posedge clk); #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_exercise_basic();
    test_hold();
    test_quadratic_tie();
    test_linear();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
